// File: rtl/avalon_flash_responder_if.sv
//------------------------------------------------------------------------------
// avalon_flash_responder_if : Avalon-MM read bus between the flash initiator and the responder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface avalon_flash_responder_if;
    logic [22:0] flash_mem_address;
    logic        flash_mem_read;
    logic [6:0]  flash_mem_burstcount;
    logic [3:0]  flash_mem_byteenable;
    logic        flash_mem_waitrequest;
    logic [31:0] flash_mem_readdata;
    logic        flash_mem_readdatavalid;

    modport master (
        output flash_mem_address,
        output flash_mem_read,
        output flash_mem_burstcount,
        output flash_mem_byteenable,
        input  flash_mem_waitrequest,
        input  flash_mem_readdata,
        input  flash_mem_readdatavalid
    );

    modport slave (
        input  flash_mem_address,
        input  flash_mem_read,
        input  flash_mem_burstcount,
        input  flash_mem_byteenable,
        output flash_mem_waitrequest,
        output flash_mem_readdata,
        output flash_mem_readdatavalid
    );
endinterface

`default_nettype wire

// File: rtl/avalon_flash_responder.sv
//------------------------------------------------------------------------------
// avalon_flash_responder : flash read responder returning address-derived burst
// data after a fixed latency. Optional LFSR stall injection: FLASH_RESP_STALL_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module avalon_flash_responder #(
    parameter int unsigned READ_LATENCY = 3,
    parameter int unsigned MAX_BURST    = 64
) (
    input  wire                             clk,
    input  wire                             RST,
    avalon_flash_responder_if.slave         flash_mem,
    input  wire                             toggle_busy,
    output logic                            cmd_error
);

    localparam logic [3:0] c_LAT_LOAD  = 4'(READ_LATENCY - 1);
    localparam logic [6:0] c_MAX_BURST = 7'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAT    = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t      r_state,         w_state_nxt;
    logic [22:0] r_beat_addr,     w_beat_addr_nxt;
    logic [6:0]  r_beats_left,    w_beats_left_nxt;
    logic [3:0]  r_lat_cnt,       w_lat_cnt_nxt;
    logic [31:0] r_readdata,      w_readdata_nxt;
    logic        r_readdatavalid, w_readdatavalid_nxt;
    logic        r_cmd_error,     w_cmd_error_nxt;

    logic w_stall_idle;
    logic w_stall_stream;
    logic w_waitrequest;
    logic w_accept;
    logic w_burst_legal;
    logic w_gap;
    logic w_emit;
    logic w_unused_byteenable;

    // Byte enables are part of the bus contract only; whole words are returned.
    assign w_unused_byteenable = &flash_mem.flash_mem_byteenable;

`ifdef FLASH_RESP_STALL_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_stall_idle   = r_lfsr[0];
    assign w_stall_stream = &r_lfsr[1:0];
`else
    assign w_stall_idle   = 1'b0;
    assign w_stall_stream = 1'b0;
`endif

    assign w_waitrequest = (r_state != S_IDLE) | toggle_busy | ~RST | w_stall_idle;
    assign w_accept      = (r_state == S_IDLE) & flash_mem.flash_mem_read & ~w_waitrequest;
    assign w_burst_legal = (flash_mem.flash_mem_burstcount != 7'd0) &&
                           (flash_mem.flash_mem_burstcount <= c_MAX_BURST);
    assign w_gap         = toggle_busy | w_stall_stream;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state         <= S_IDLE;
            r_beat_addr     <= 23'd0;
            r_beats_left    <= 7'd0;
            r_lat_cnt       <= 4'd0;
            r_readdata      <= 32'h0;
            r_readdatavalid <= 1'b0;
            r_cmd_error     <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_beat_addr     <= w_beat_addr_nxt;
            r_beats_left    <= w_beats_left_nxt;
            r_lat_cnt       <= w_lat_cnt_nxt;
            r_readdata      <= w_readdata_nxt;
            r_readdatavalid <= w_readdatavalid_nxt;
            r_cmd_error     <= w_cmd_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_beat_addr_nxt     = r_beat_addr;
        w_beats_left_nxt    = r_beats_left;
        w_lat_cnt_nxt       = r_lat_cnt;
        w_readdata_nxt      = r_readdata;
        w_readdatavalid_nxt = 1'b0;
        w_cmd_error_nxt     = r_cmd_error;
        w_emit              = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_beat_addr_nxt  = flash_mem.flash_mem_address;
                    w_beats_left_nxt = flash_mem.flash_mem_burstcount;
                    w_lat_cnt_nxt    = c_LAT_LOAD;
                    // Illegal bursts are swallowed: no beats, sticky error.
                    if (w_burst_legal) begin
                        w_state_nxt = S_LAT;
                    end else begin
                        w_cmd_error_nxt = 1'b1;
                    end
                end
            end
            S_LAT: begin
                if (r_lat_cnt == 4'd0) begin
                    w_emit      = 1'b1;
                    w_state_nxt = (r_beats_left == 7'd1) ? S_IDLE : S_STREAM;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - 4'd1;
                end
            end
            S_STREAM: begin
                if (!w_gap) begin
                    w_emit = 1'b1;
                    if (r_beats_left == 7'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Leaving on the last beat lets the next command land one edge later.
        if (w_emit) begin
            w_readdata_nxt      = {~r_beat_addr[15:0], r_beat_addr[15:0]};
            w_readdatavalid_nxt = 1'b1;
            w_beat_addr_nxt     = r_beat_addr + 23'd1;
            w_beats_left_nxt    = r_beats_left - 7'd1;
        end
    end

    assign flash_mem.flash_mem_waitrequest   = w_waitrequest;
    assign flash_mem.flash_mem_readdata      = r_readdata;
    assign flash_mem.flash_mem_readdatavalid = r_readdatavalid;
    assign cmd_error                         = r_cmd_error;

endmodule

`default_nettype wire
